// File: rtl/flex_counter_mc_pkg.sv
// flex_counter_pkg: shared types and the per-channel step rule.
// No ports; holds cnt_dir_t, cnt_step_t and next_count().
package flex_counter_pkg;

  localparam int unsigned CNT_MAX_W = 32;

  typedef enum logic {
    CNT_UP   = 1'b0,
    CNT_DOWN = 1'b1
  } cnt_dir_t;

  typedef struct packed {
    logic                 wrap;
    logic [CNT_MAX_W-1:0] next;
  } cnt_step_t;

  // Values stay within R after a step, so no modulo is
  // ever needed even though the math is done wide.
  function automatic cnt_step_t next_count(
    input logic [CNT_MAX_W-1:0] count,
    input logic [CNT_MAX_W-1:0] r,
    input cnt_dir_t             dir
  );
    cnt_step_t s;
    s.wrap = 1'b0;
    s.next = count;
    if (r == '0) begin
      s.next = '0;
    end else if (dir == CNT_UP) begin
      if (count >= r) begin
        s.next = 32'd1;
        s.wrap = 1'b1;
      end else begin
        s.next = count + 32'd1;
      end
    end else begin
      if (count <= 32'd1) begin
        s.next = r;
        s.wrap = 1'b1;
      end else if (count > r) begin
        s.next = r;
      end else begin
        s.next = count - 32'd1;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/flex_counter_mc_if.sv
// flex_counter_mc_if: control/status bundle of the counter.
// master drives clear/enable/dir/load/values; slave returns count/flag/wrap.
interface flex_counter_mc_if #(
  parameter int unsigned NUM_CNT_BITS = 4,
  parameter int unsigned NUM_CH       = 2
);

  logic [NUM_CH-1:0]                   clear;
  logic [NUM_CH-1:0]                   count_enable;
  logic [NUM_CH-1:0]                   count_down;
  logic [NUM_CH-1:0]                   load;
  logic [NUM_CH-1:0][NUM_CNT_BITS-1:0] load_val;
  logic [NUM_CH-1:0][NUM_CNT_BITS-1:0] rollover_val;
  logic [NUM_CH-1:0][NUM_CNT_BITS-1:0] count_out;
  logic [NUM_CH-1:0]                   rollover_flag;
  logic [NUM_CH-1:0]                   wrap_pulse;

  modport master (
    output clear, count_enable, count_down, load,
    output load_val, rollover_val,
    input  count_out, rollover_flag, wrap_pulse
  );

  modport slave (
    input  clear, count_enable, count_down, load,
    input  load_val, rollover_val,
    output count_out, rollover_flag, wrap_pulse
  );

endinterface

// File: rtl/flex_counter_mc_ch.sv
// flex_counter_ch: one rollover counter channel with flag and wrap pulse.
// i_clk/i_rst, i_clear/i_en/i_down/i_load, i_load_val, i_rval, i_carry_in;
// o_count/o_flag/o_wrap_pulse; o_wrap_evt only with FLEX_COUNTER_CASCADE_EN.
module flex_counter_ch
  import flex_counter_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic         i_down,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic [W-1:0] i_rval,
  input  logic         i_carry_in,
  output logic [W-1:0] o_count,
  output logic         o_flag,
  output logic         o_wrap_pulse
`ifdef FLEX_COUNTER_CASCADE_EN
  ,
  output logic         o_wrap_evt
`endif
);

  logic [W-1:0] r_count;
  logic         r_flag;
  logic         r_wrap;

  cnt_dir_t     w_dir;
  cnt_step_t    w_nx;
  logic [W-1:0] w_term;
  logic         w_nz;
  logic         w_step;
  logic         w_wrap_evt;
  logic         w_nx_term;
  logic         w_ld_term;

  always_comb begin
    w_dir  = i_down ? CNT_DOWN : CNT_UP;
    w_term = i_down ? W'(1) : i_rval;
    w_nz   = |i_rval;
    w_nx   = next_count(CNT_MAX_W'(r_count),
                        CNT_MAX_W'(i_rval), w_dir);
    w_step = i_en & i_carry_in;
    // clear/load on the wrap cycle kill the wrap and the carry.
    w_wrap_evt = w_step & w_nx.wrap
               & ~i_clear & ~i_load & ~i_rst;
    // R==0 keeps the flag low even though next==R==0.
    w_nx_term = w_nz & (w_nx.next == CNT_MAX_W'(w_term));
    w_ld_term = w_nz & (i_load_val == w_term);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
      r_flag  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (i_clear) begin
      r_count <= '0;
      r_flag  <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (i_load) begin
      r_count <= i_load_val;
      r_flag  <= w_ld_term;
      r_wrap  <= 1'b0;
    end else if (w_step) begin
      r_count <= w_nx.next[W-1:0];
      r_flag  <= w_nx_term;
      r_wrap  <= w_wrap_evt;
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  assign o_count      = r_count;
  assign o_flag       = r_flag;
  assign o_wrap_pulse = r_wrap;
`ifdef FLEX_COUNTER_CASCADE_EN
  assign o_wrap_evt   = w_wrap_evt;
`endif

endmodule

// File: rtl/flex_counter_mc.sv
// flex_counter_mc: NUM_CH flexible rollover counters behind one interface.
// Ports: clk, rst (sync, active high), bus (flex_counter_mc_if.slave).
// FLEX_COUNTER_CASCADE_EN chains channel k-1 wrap into channel k step.
module flex_counter_mc
  import flex_counter_pkg::*;
#(
  parameter int unsigned NUM_CNT_BITS = 4,
  parameter int unsigned NUM_CH       = 2
) (
  input logic              clk,
  input logic              rst,
  flex_counter_mc_if.slave bus
);

  logic [NUM_CH-1:0][NUM_CNT_BITS-1:0] w_count;
  logic [NUM_CH-1:0]                   w_flag;
  logic [NUM_CH-1:0]                   w_wrap;
  logic [NUM_CH-1:0]                   w_carry;
`ifdef FLEX_COUNTER_CASCADE_EN
  logic [NUM_CH-1:0]                   w_wrap_evt;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
`ifdef FLEX_COUNTER_CASCADE_EN
    // Same-cycle ripple: all channels move on one edge.
    if (k == 0) begin : g_head
      assign w_carry[k] = 1'b1;
    end else begin : g_link
      assign w_carry[k] = w_wrap_evt[k-1];
    end
`else
    assign w_carry[k] = 1'b1;
`endif

    flex_counter_ch #(
      .W (NUM_CNT_BITS)
    ) u_ch (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_clear      (bus.clear[k]),
      .i_en         (bus.count_enable[k]),
      .i_down       (bus.count_down[k]),
      .i_load       (bus.load[k]),
      .i_load_val   (bus.load_val[k]),
      .i_rval       (bus.rollover_val[k]),
      .i_carry_in   (w_carry[k]),
      .o_count      (w_count[k]),
      .o_flag       (w_flag[k]),
      .o_wrap_pulse (w_wrap[k])
`ifdef FLEX_COUNTER_CASCADE_EN
      ,
      .o_wrap_evt   (w_wrap_evt[k])
`endif
    );
  end

  assign bus.count_out     = w_count;
  assign bus.rollover_flag = w_flag;
  assign bus.wrap_pulse    = w_wrap;

endmodule
